branch_pht: RTL and testbench

Parametrised pattern history table for the branch predictor: an array of N-bit saturating counters indexed by PC bits, optionally XOR-hashed with a global history register (gshare). It generalises the 2-bit counter next-value logic to any counter width and table depth and adds registered lookup, update write-back, same-cycle forwarding and history tracking. It sits between the fetch stage, which issues lookups, and the branch-resolution stage, which issues updates.

---
 rtl/branch_pht_pkg.sv | 14 +
 rtl/sat_counter_next.sv | 26 ++
 rtl/branch_pht.sv | 100 ++++++++++
 tb/tb_branch_pht.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pht_pkg.sv
// Shared branch-predictor constants: default table geometry and the
// weakly-not-taken counter value used to initialise every PHT entry.
package branch_pht_pkg;

    localparam int DEFAULT_CTR_WIDTH   = 2;
    localparam int DEFAULT_INDEX_WIDTH = 6;
    localparam int DEFAULT_USE_GHR     = 1;

    // Weakly-not-taken: MSB clear, all lower bits set (01, 011, 0111, ...).
    function automatic int weakNotTaken(input int ctrWidth);
        return (1 << (ctrWidth - 1)) - 1;
    endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Next-value logic for one saturating up/down counter of any width.
// Taken counts up and sticks at all-ones, not-taken counts down and sticks
// at zero, so the counter never wraps.
module sat_counter_next #(
    parameter int CTR_WIDTH = 2
) (
    input  logic [CTR_WIDTH-1:0] curCtr,
    input  logic                 taken,
    output logic [CTR_WIDTH-1:0] nextCtr
);

    // Step toward the resolved direction unless already at that end.
    always_comb begin
        nextCtr = curCtr;
        if (taken) begin
            if (curCtr != '1) begin
                nextCtr = curCtr + 1'b1;
            end
        end else begin
            if (curCtr != '0) begin
                nextCtr = curCtr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_pht.sv
// Pattern history table: 2^INDEX_WIDTH saturating counters, optionally
// gshare-indexed with the global history register. Lookups from fetch are
// registered (one-cycle latency); updates from branch resolution write back
// on the same edge, with same-index same-cycle updates forwarded into the
// prediction.
//
// Valid semantics: lookup_valid and update_valid are single-cycle requests
// with no ready/back-pressure; each one presented at an edge is consumed at
// that edge. predict_valid is high for exactly the cycle after an accepted
// lookup, and predict_ctr/predict_taken hold their value otherwise.
module branch_pht
    import branch_pht_pkg::*;
#(
    parameter int CTR_WIDTH   = DEFAULT_CTR_WIDTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int USE_GHR     = DEFAULT_USE_GHR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lookup_valid,
    input  logic [INDEX_WIDTH-1:0] lookup_pc_idx,
    output logic                   predict_valid,
    output logic                   predict_taken,
    output logic [CTR_WIDTH-1:0]   predict_ctr,
    input  logic                   update_valid,
    input  logic [INDEX_WIDTH-1:0] update_pc_idx,
    input  logic                   update_taken,
    output logic [INDEX_WIDTH-1:0] ghr
);

    localparam int                   DEPTH   = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(weakNotTaken(CTR_WIDTH));

    logic [CTR_WIDTH-1:0]   phtTable [DEPTH];
    logic [INDEX_WIDTH-1:0] ghrReg;
    logic [INDEX_WIDTH-1:0] histMask;
    logic [INDEX_WIDTH-1:0] lookupIdx;
    logic [INDEX_WIDTH-1:0] updateIdx;
    logic [CTR_WIDTH-1:0]   updateCur;
    logic [CTR_WIDTH-1:0]   updateNext;
    logic [CTR_WIDTH-1:0]   lookupCtr;
    logic                   fwdHit;

    assign ghr = ghrReg;

    // Both indices hash with the history as it stood before this edge.
    assign histMask  = (USE_GHR != 0) ? ghrReg : '0;
    assign lookupIdx = lookup_pc_idx ^ histMask;
    assign updateIdx = update_pc_idx ^ histMask;

    assign updateCur = phtTable[updateIdx];

    sat_counter_next #(
        .CTR_WIDTH(CTR_WIDTH)
    ) u_satNext (
        .curCtr (updateCur),
        .taken  (update_taken),
        .nextCtr(updateNext)
    );

    // A same-cycle update to the looked-up entry wins over the stale value.
    assign fwdHit    = update_valid && (updateIdx == lookupIdx);
    assign lookupCtr = fwdHit ? updateNext : phtTable[lookupIdx];

    // Counter table: reset to weakly-not-taken, write back resolved branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                phtTable[i] <= WEAK_NT;
            end
        end else if (update_valid) begin
            phtTable[updateIdx] <= updateNext;
        end
    end

    // Global history: shift in each resolved direction, newest at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghrReg <= '0;
        end else if (update_valid) begin
            ghrReg <= {ghrReg[INDEX_WIDTH-2:0], update_taken};
        end
    end

    // Prediction registers: capture on lookup, otherwise hold the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
            predict_ctr   <= WEAK_NT;
        end else begin
            predict_valid <= lookup_valid;
            if (lookup_valid) begin
                predict_ctr   <= lookupCtr;
                predict_taken <= lookupCtr[CTR_WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_branch_pht.sv
// Bench for branch_pht: three instances (2-bit plain index, 2-bit gshare,
// 3-bit plain index) share one stimulus stream. An integer reference model
// predicts each lookup result, which is queued when the lookup is driven
// and popped when the registered prediction appears.
module tb_branch_pht;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lookup_valid = 1'b0;
    logic [5:0] lookup_pc_idx = '0;
    logic       update_valid = 1'b0;
    logic [5:0] update_pc_idx = '0;
    logic       update_taken = 1'b0;

    logic       pv0, pt0, pv1, pt1, pv2, pt2;
    logic [1:0] pc0, pc1;
    logic [2:0] pc2;
    logic [5:0] g0, g1, g2;

    int checks = 0;
    int failures = 0;

    int         model [3][64];
    int         mGhr [3];
    logic [3:0] lastExp [3];
    logic [3:0] expQ0 [$];
    logic [3:0] expQ1 [$];
    logic [3:0] expQ2 [$];

    always #5 clk = ~clk;

    branch_pht #(.CTR_WIDTH(2), .INDEX_WIDTH(6), .USE_GHR(0)) dut0 (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc_idx(lookup_pc_idx),
        .predict_valid(pv0), .predict_taken(pt0), .predict_ctr(pc0),
        .update_valid(update_valid), .update_pc_idx(update_pc_idx),
        .update_taken(update_taken), .ghr(g0)
    );

    branch_pht #(.CTR_WIDTH(2), .INDEX_WIDTH(6), .USE_GHR(1)) dut1 (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc_idx(lookup_pc_idx),
        .predict_valid(pv1), .predict_taken(pt1), .predict_ctr(pc1),
        .update_valid(update_valid), .update_pc_idx(update_pc_idx),
        .update_taken(update_taken), .ghr(g1)
    );

    branch_pht #(.CTR_WIDTH(3), .INDEX_WIDTH(6), .USE_GHR(0)) dut2 (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc_idx(lookup_pc_idx),
        .predict_valid(pv2), .predict_taken(pt2), .predict_ctr(pc2),
        .update_valid(update_valid), .update_pc_idx(update_pc_idx),
        .update_taken(update_taken), .ghr(g2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wOf(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int useG(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int resetCtr(input int d);
        return (1 << (wOf(d) - 1)) - 1;
    endfunction

    function automatic logic [3:0] dutPred(input int d);
        case (d)
            0:       return {pt0, 1'b0, pc0};
            1:       return {pt1, 1'b0, pc1};
            default: return {pt2, pc2};
        endcase
    endfunction

    function automatic logic dutValid(input int d);
        case (d)
            0:       return pv0;
            1:       return pv1;
            default: return pv2;
        endcase
    endfunction

    function automatic logic [5:0] dutGhr(input int d);
        case (d)
            0:       return g0;
            1:       return g1;
            default: return g2;
        endcase
    endfunction

    function automatic int modelNext(input int d, input int idx, input logic ut);
        int cur = model[d][idx];
        int top = (1 << wOf(d)) - 1;
        if (ut) return (cur == top) ? top : cur + 1;
        return (cur == 0) ? 0 : cur - 1;
    endfunction

    function automatic logic [3:0] modelPredict(input int d, input logic [5:0] li,
                                                input logic uv, input logic [5:0] ui,
                                                input logic ut);
        int mask = (useG(d) != 0) ? mGhr[d] : 0;
        int lIdx = int'(li) ^ mask;
        int uIdx = int'(ui) ^ mask;
        int v;
        if (uv && (lIdx == uIdx)) v = modelNext(d, uIdx, ut);
        else                      v = model[d][lIdx];
        return {1'((v >> (wOf(d) - 1)) & 1), 3'(v)};
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 64; i++) model[d][i] = resetCtr(d);
            mGhr[d] = 0;
            lastExp[d] = {1'b0, 3'(resetCtr(d))};
        end
        expQ0.delete();
        expQ1.delete();
        expQ2.delete();
    endtask

    task automatic checkResetState(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_valid%0d", tag, d), 32'(dutValid(d)), 32'd0);
            check($sformatf("%s_pred%0d", tag, d), 32'(dutPred(d)), 32'(resetCtr(d)));
            check($sformatf("%s_ghr%0d", tag, d), 32'(dutGhr(d)), 32'd0);
        end
    endtask

    // One clock of stimulus: queue expectations, advance the model, then
    // compare the registered outputs just after the edge.
    task automatic cycle(input logic lv, input logic [5:0] li,
                         input logic uv, input logic [5:0] ui, input logic ut);
        logic [3:0] e;
        lookup_valid  = lv;
        lookup_pc_idx = li;
        update_valid  = uv;
        update_pc_idx = ui;
        update_taken  = ut;
        for (int d = 0; d < 3; d++) begin
            if (lv) begin
                e = modelPredict(d, li, uv, ui, ut);
                case (d)
                    0:       expQ0.push_back(e);
                    1:       expQ1.push_back(e);
                    default: expQ2.push_back(e);
                endcase
            end
            if (uv) begin
                int mask = (useG(d) != 0) ? mGhr[d] : 0;
                int uIdx = int'(ui) ^ mask;
                model[d][uIdx] = modelNext(d, uIdx, ut);
                mGhr[d] = ((mGhr[d] << 1) | int'(ut)) & 63;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("valid%0d", d), 32'(dutValid(d)), 32'(lv));
            if (lv) begin
                case (d)
                    0:       e = (expQ0.size() > 0) ? expQ0.pop_front() : 4'hf;
                    1:       e = (expQ1.size() > 0) ? expQ1.pop_front() : 4'hf;
                    default: e = (expQ2.size() > 0) ? expQ2.pop_front() : 4'hf;
                endcase
                lastExp[d] = e;
                check($sformatf("pred%0d", d), 32'(dutPred(d)), 32'(e));
            end else begin
                check($sformatf("hold%0d", d), 32'(dutPred(d)), 32'(lastExp[d]));
            end
            check($sformatf("ghr%0d", d), 32'(dutGhr(d)), 32'(mGhr[d]));
        end
        lookup_valid = 1'b0;
        update_valid = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; requests during it are dropped.
    task automatic doReset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        checkResetState({tag, "_async"});
        lookup_valid  = 1'b1;
        lookup_pc_idx = 6'd2;
        update_valid  = 1'b1;
        update_pc_idx = 6'd2;
        update_taken  = 1'b1;
        @(posedge clk);
        #1;
        checkResetState({tag, "_held"});
        rst = 1'b0;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        modelReset();
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("por");
        rst = 1'b0;

        // Default entry after reset.
        cycle(1, 6'd5, 0, 6'd0, 0);
        check("def_ctr", 32'(pc0), 32'd1);
        check("def_taken", 32'(pt0), 32'd0);

        // Same-cycle forwarding on idx 7.
        cycle(1, 6'd7, 1, 6'd7, 1);
        check("fwd_ctr", 32'(pc0), 32'd2);
        check("fwd_taken", 32'(pt0), 32'd1);

        // Saturate up at idx 3.
        repeat (4) cycle(0, 6'd0, 1, 6'd3, 1);
        cycle(1, 6'd3, 0, 6'd0, 0);
        check("satup_ctr", 32'(pc0), 32'd3);
        check("satup_taken", 32'(pt0), 32'd1);
        check("satup_ctr3", 32'(pc2), 32'd7);
        cycle(0, 6'd0, 1, 6'd3, 1);
        cycle(1, 6'd3, 0, 6'd0, 0);
        check("satup_hold", 32'(pc0), 32'd3);
        check("satup_hold3", 32'(pc2), 32'd7);

        // Saturate down at idx 3.
        repeat (3) cycle(0, 6'd0, 1, 6'd3, 0);
        cycle(1, 6'd3, 0, 6'd0, 0);
        check("satdn_ctr", 32'(pc0), 32'd0);
        check("satdn_ctr3", 32'(pc2), 32'd4);
        repeat (5) cycle(0, 6'd0, 1, 6'd3, 0);
        cycle(1, 6'd3, 0, 6'd0, 0);
        check("satdn_hold", 32'(pc0), 32'd0);
        check("satdn_taken", 32'(pt0), 32'd0);
        check("satdn_hold3", 32'(pc2), 32'd0);

        // Gshare indexing.
        doReset("gs");
        cycle(0, 6'd0, 1, 6'd0, 1);
        cycle(0, 6'd0, 1, 6'd0, 1);
        cycle(0, 6'd0, 1, 6'd0, 0);
        check("gs_ghr", 32'(g1), 32'h06);
        cycle(1, 6'b000110, 1, 6'b000110, 1);
        check("gs_fwd_entry0", 32'(pc1), 32'd3);
        check("gs_plain_entry6", 32'(pc0), 32'd2);
        cycle(1, 6'b001101, 0, 6'd0, 0);
        check("gs_entry0", 32'(pc1), 32'd3);

        // Random traffic over a small index range to force collisions.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
        end

        // Train idx 2, then reset mid-operation.
        repeat (4) cycle(0, 6'd0, 1, 6'd2, 1);
        cycle(1, 6'd2, 0, 6'd0, 0);
        check("mid_trained", 32'(pc0), 32'd3);
        doReset("mid");
        cycle(1, 6'd2, 0, 6'd0, 0);
        check("mid_ctr", 32'(pc0), 32'd1);
        check("mid_ctr3", 32'(pc2), 32'd3);

        check("queues_empty", 32'(expQ0.size() + expQ1.size() + expQ2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
